// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for one single-port unified memory
//
// Purpose: shares one memory between the instruction-fetch path and the
// load/store path. At most one access is outstanding. Its response is routed
// back to the requester that owns it. Data requests have fixed priority over
// fetch. An optional starvation guard forces a waiting fetch ahead after
// STARVE_LIMIT consecutive data grants.
//
// Build option: MINIRV_ARB_STARVE_GUARD_EN enables the starvation guard.
// When it is undefined, data strictly wins and STARVE_LIMIT is ignored.
//
// Parameters:
//   LATENCY       cycles from mem_en to valid mem_rdata (1..4)
//   STARVE_LIMIT  data grants a pending fetch tolerates (1..15)
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   if_req/if_addr                     fetch request, byte address
//   if_gnt                             fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata                 fetch response pulse and data
//   d_req/d_we/d_addr/d_wdata/d_wstrb  load/store request
//   d_gnt                              data accepted this cycle (combinational)
//   d_rvalid/d_rdata                   data response pulse, load data (0 for stores)
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_wstrb                memory access issued this cycle
//   mem_rdata                          memory read data, LATENCY cycles after mem_en

module mem_port_arbiter #(
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [1:0]  LAT_LAST  = 2'(LATENCY - 1);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic       is_write_q, is_write_d;
  logic [1:0] lat_q, lat_d;

  logic resp_cycle;
  logic resp_ok;
  logic can_issue;
  logic forced_fetch;
  logic grant_if;
  logic grant_d;

  // The response cycle of the outstanding access is also a free issue slot,
  // which is what lets LATENCY=1 sustain one grant per cycle.
  assign resp_cycle = (state_q == ST_BUSY) && (lat_q == LAT_LAST);
  assign can_issue  = (state_q == ST_IDLE) || resp_cycle;

`ifdef MINIRV_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign forced_fetch = if_req && (starve_q == STARVE_MAX);

  // Counts data grants that overtook a waiting fetch; a withdrawn or
  // served fetch starts the count over.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || grant_if) begin
      starve_d = 4'd0;
    end else if (grant_d && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign forced_fetch = 1'b0;
`endif

  // Grants are masked during reset so nothing reaches memory while the
  // state is being cleared.
  assign grant_d  = !reset && can_issue && d_req && !forced_fetch;
  assign grant_if = !reset && can_issue && if_req && (forced_fetch || !d_req);

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign mem_en    = grant_if || grant_d;
  assign mem_we    = grant_d && d_we;
  assign mem_addr  = grant_d  ? (d_addr & WORD_MASK) :
                     grant_if ? (if_addr & WORD_MASK) : 32'd0;
  assign mem_wdata = grant_d ? d_wdata : 32'd0;
  assign mem_wstrb = (grant_d && d_we) ? d_wstrb : 4'b0000;

  // A reset in the response cycle drops the access, so no pulse escapes.
  assign resp_ok   = resp_cycle && !reset;
  assign if_rvalid = resp_ok && (owner_q == OWN_IF);
  assign d_rvalid  = resp_ok && (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign d_rdata   = (d_rvalid && !is_write_q) ? mem_rdata : 32'd0;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    owner_d    = owner_q;
    is_write_d = is_write_q;
    if (grant_if || grant_d) begin
      state_d    = ST_BUSY;
      lat_d      = 2'd0;
      owner_d    = grant_d ? OWN_D : OWN_IF;
      is_write_d = grant_d && d_we;
    end else if (state_q == ST_BUSY) begin
      if (lat_q == LAT_LAST) begin
        state_d = ST_IDLE;
      end else begin
        lat_d = lat_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lat_q      <= 2'd0;
      owner_q    <= OWN_IF;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      owner_q    <= owner_d;
      is_write_q <= is_write_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at LATENCY 1, 2 and 3

module tb_mem_port_arbiter;

  localparam int SL = 3;
`ifdef MINIRV_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance k runs with LATENCY = k + 1.
  logic        reset     [3];
  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic        if_gnt    [3];
  logic        if_rvalid [3];
  logic [31:0] if_rdata  [3];
  logic        d_req     [3];
  logic        d_we      [3];
  logic [31:0] d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic [3:0]  d_wstrb   [3];
  logic        d_gnt     [3];
  logic        d_rvalid  [3];
  logic [31:0] d_rdata   [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_wstrb [3];
  logic [31:0] mem_rdata [3];

  logic [31:0] ref_mem [3][64];

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LAT = k + 1;

    mem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SL)) u_dut (
      .clk(clk), .reset(reset[k]),
      .if_req(if_req[k]), .if_addr(if_addr[k]), .if_gnt(if_gnt[k]),
      .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]),
      .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_wstrb(d_wstrb[k]), .d_gnt(d_gnt[k]), .d_rvalid(d_rvalid[k]), .d_rdata(d_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_wstrb(mem_wstrb[k]), .mem_rdata(mem_rdata[k])
    );

    // Memory model: read data is driven only in the cycle LAT after the access.
    logic [31:0] smem [64];
    logic [31:0] rd_hold;
    int          rd_cnt;

    initial begin
      for (int i = 0; i < 64; i++) smem[i] = init_word(i);
      rd_hold = 32'd0;
      rd_cnt  = 0;
    end

    always @(posedge clk) begin
      if (mem_en[k]) begin
        rd_hold <= smem[mem_addr[k][7:2]];
        rd_cnt  <= LAT;
        if (mem_we[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[k][b]) smem[mem_addr[k][7:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
          end
        end
      end else if (rd_cnt > 0) begin
        rd_cnt <= rd_cnt - 1;
      end
    end

    assign mem_rdata[k] = (rd_cnt == 1) ? rd_hold : 32'hDEAD_BEEF;
  end

  task automatic idle_inputs(input int k);
    if_req[k]  = 1'b0;
    if_addr[k] = 32'd0;
    d_req[k]   = 1'b0;
    d_we[k]    = 1'b0;
    d_addr[k]  = 32'd0;
    d_wdata[k] = 32'd0;
    d_wstrb[k] = 4'd0;
  endtask

  task automatic ref_store(input int k, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) ref_mem[k][a[7:2]][8*b +: 8] = w[8*b +: 8];
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1; if_req[k] = 1'b1; if_addr[k] = 32'h44;
      d_req[k] = 1'b1; d_we[k] = 1'b1; d_addr[k] = 32'h48;
      d_wdata[k] = 32'hFFFF_FFFF; d_wstrb[k] = 4'hF;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({if_gnt[k], d_gnt[k], mem_en[k], mem_we[k], mem_wstrb[k], if_rvalid[k], d_rvalid[k]} !== 10'b0)
        begin fails++; $display("FAIL reset_ctrl k=%0d got=%b exp=0", k,
          {if_gnt[k], d_gnt[k], mem_en[k], mem_we[k], mem_wstrb[k], if_rvalid[k], d_rvalid[k]}); end
      tests++;
      if ({if_rdata[k], d_rdata[k]} !== 64'd0)
        begin fails++; $display("FAIL reset_rdata k=%0d got=%h/%h exp=0", k, if_rdata[k], d_rdata[k]); end
    end
    for (int k = 0; k < 3; k++) begin idle_inputs(k); reset[k] = 1'b0; end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    #1;
    tests++;
    if ({if_gnt[0], d_gnt[0], mem_en[0], mem_we[0]} !== 4'b1010 || mem_addr[0] !== 32'h10)
      begin fails++; $display("FAIL fetch_issue got=%b addr=%h exp=1010 addr=10",
        {if_gnt[0], d_gnt[0], mem_en[0], mem_we[0]}, mem_addr[0]); end
    @(negedge clk);
    if_req[0] = 1'b0;
    #1;
    tests++;
    if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== ref_mem[0][4])
      begin fails++; $display("FAIL fetch_resp got=%b/%h exp=1/%h", if_rvalid[0], if_rdata[0], ref_mem[0][4]); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h22; d_wdata[0] = 32'h1234_5678; d_wstrb[0] = 4'b0100;
    #1;
    tests++;
    if ({d_gnt[0], if_gnt[0], mem_we[0]} !== 3'b101 || mem_addr[0] !== 32'h20 || mem_wstrb[0] !== 4'b0100)
      begin fails++; $display("FAIL contention_issue got=%b addr=%h strb=%b exp=101 addr=20 strb=0100",
        {d_gnt[0], if_gnt[0], mem_we[0]}, mem_addr[0], mem_wstrb[0]); end
    ref_store(0, 32'h22, 32'h1234_5678, 4'b0100);
    @(negedge clk);
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    #1;
    tests++;
    if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'd0 || if_gnt[0] !== 1'b1)
      begin fails++; $display("FAIL contention_resp got rv=%b rd=%h ig=%b exp rv=1 rd=0 ig=1",
        d_rvalid[0], d_rdata[0], if_gnt[0]); end
    @(negedge clk);
    if_req[0] = 1'b0;
    #1;
    tests++;
    if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== ref_mem[0][8])
      begin fails++; $display("FAIL contention_fetch got=%b/%h exp=1/%h", if_rvalid[0], if_rdata[0], ref_mem[0][8]); end
  endtask

  task automatic test_starvation();
    bit exp_i;
    @(negedge clk);
    idle_inputs(0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if_req[0] = 1'b1; if_addr[0] = 32'h04;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h08;
      #1;
      exp_i = GUARD && ((i % 4) == 3);
      tests++;
      if ({if_gnt[0], d_gnt[0]} !== {exp_i, !exp_i})
        begin fails++; $display("FAIL starvation i=%0d got ig/dg=%b exp=%b", i, {if_gnt[0], d_gnt[0]}, {exp_i, !exp_i}); end
    end
    @(negedge clk);
    idle_inputs(0);
    @(negedge clk);
  endtask

  task automatic test_latency3();
    @(negedge clk);
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h30;
    #1;
    tests++;
    if (d_gnt[2] !== 1'b1) begin fails++; $display("FAIL lat3_issue got=%b exp=1", d_gnt[2]); end
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      d_req[2] = 1'b0;
      if_req[2] = (t <= 3); if_addr[2] = 32'h50;
      #1;
      if (t < 3) begin
        tests++;
        if ({if_gnt[2], d_gnt[2], d_rvalid[2]} !== 3'b000)
          begin fails++; $display("FAIL lat3_wait t=%0d got=%b exp=000", t, {if_gnt[2], d_gnt[2], d_rvalid[2]}); end
      end else if (t == 3) begin
        tests++;
        if (d_rvalid[2] !== 1'b1 || d_rdata[2] !== ref_mem[2][12] || if_gnt[2] !== 1'b1)
          begin fails++; $display("FAIL lat3_resp got rv=%b rd=%h ig=%b exp rv=1 rd=%h ig=1",
            d_rvalid[2], d_rdata[2], if_gnt[2], ref_mem[2][12]); end
      end else begin
        tests++;
        if (if_rvalid[2] !== (t == 6) || if_rdata[2] !== ((t == 6) ? ref_mem[2][20] : 32'd0))
          begin fails++; $display("FAIL lat3_fetch t=%0d got=%b/%h", t, if_rvalid[2], if_rdata[2]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req[1] = 1'b1; if_addr[1] = 32'h40;
    #1;
    tests++;
    if (if_gnt[1] !== 1'b1) begin fails++; $display("FAIL rstmid_issue got=%b exp=1", if_gnt[1]); end
    @(negedge clk);
    if_req[1] = 1'b0; reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      tests++;
      if ({if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1], mem_en[1], mem_we[1], mem_wstrb[1]} !== 10'b0 ||
          {if_rdata[1], d_rdata[1], mem_addr[1], mem_wdata[1]} !== 128'd0)
        begin fails++; $display("FAIL rstmid_idle t=%0d got ctl=%b rv=%b/%b", t,
          {if_gnt[1], d_gnt[1], mem_en[1], mem_we[1], mem_wstrb[1]}, if_rvalid[1], d_rvalid[1]); end
      @(negedge clk);
    end
  endtask

  // Reference: an access accepted at cycle c answers at c+LAT, and that answer
  // cycle is again free for a new accept.
  task automatic test_random(input int k, input int ncyc);
    int          lat;
    int          due;
    int          streak;
    bit          ip, dp, busy, own_d, wr, can, forced, eig, edg, eirv, edrv;
    logic [31:0] rdat, ea, ew, erd_i, erd_d, wa;
    logic [7:0]  ectl;
    lat = k + 1; due = 0; streak = 0;
    ip = 0; dp = 0; busy = 0; own_d = 0; wr = 0; rdat = 32'd0;
    idle_inputs(k);
    reset[k] = 1'b1;
    repeat (2) @(negedge clk);
    reset[k] = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (!ip) begin
        if ($urandom_range(0, 1) == 1) begin ip = 1; if_addr[k] = $urandom; end
      end else if ($urandom_range(0, 15) == 0) ip = 0;
      if (!dp) begin
        if ($urandom_range(0, 3) != 0) begin
          dp = 1; d_we[k] = 1'($urandom_range(0, 1)); d_addr[k] = $urandom;
          d_wdata[k] = $urandom; d_wstrb[k] = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 15) == 0) dp = 0;
      if_req[k] = ip; d_req[k] = dp;
      #1;
      can    = !busy || (due == c);
      forced = GUARD && ip && (streak == SL);
      eig    = can && ip && (forced || !dp);
      edg    = can && dp && !forced;
      ea     = edg ? (d_addr[k] & 32'hFFFF_FFFC) : eig ? (if_addr[k] & 32'hFFFF_FFFC) : 32'd0;
      ew     = edg ? d_wdata[k] : 32'd0;
      ectl   = {eig, edg, eig | edg, edg & d_we[k], (edg && d_we[k]) ? d_wstrb[k] : 4'h0};
      eirv   = busy && (due == c) && !own_d;
      edrv   = busy && (due == c) && own_d;
      erd_i  = eirv ? rdat : 32'd0;
      erd_d  = (edrv && !wr) ? rdat : 32'd0;
      tests++;
      if ({if_gnt[k], d_gnt[k], mem_en[k], mem_we[k], mem_wstrb[k]} !== ectl)
        begin fails++; $display("FAIL rnd_ctrl k=%0d cyc=%0d got=%b exp=%b", k, c,
          {if_gnt[k], d_gnt[k], mem_en[k], mem_we[k], mem_wstrb[k]}, ectl); end
      tests++;
      if (mem_addr[k] !== ea || mem_wdata[k] !== ew)
        begin fails++; $display("FAIL rnd_mem k=%0d cyc=%0d got=%h/%h exp=%h/%h", k, c,
          mem_addr[k], mem_wdata[k], ea, ew); end
      tests++;
      if ({if_rvalid[k], d_rvalid[k]} !== {eirv, edrv})
        begin fails++; $display("FAIL rnd_rvalid k=%0d cyc=%0d got=%b exp=%b", k, c,
          {if_rvalid[k], d_rvalid[k]}, {eirv, edrv}); end
      tests++;
      if (if_rdata[k] !== erd_i || d_rdata[k] !== erd_d)
        begin fails++; $display("FAIL rnd_rdata k=%0d cyc=%0d got=%h/%h exp=%h/%h", k, c,
          if_rdata[k], d_rdata[k], erd_i, erd_d); end
      if (busy && (due == c)) busy = 0;
      if (eig || edg) begin
        busy  = 1;
        due   = c + lat;
        own_d = edg;
        wr    = edg && d_we[k];
        wa    = ea;
        rdat  = ref_mem[k][wa[7:2]];
        if (wr) ref_store(k, ea, d_wdata[k], d_wstrb[k]);
      end
      if (!ip || eig) streak = 0;
      else if (edg && streak < SL) streak++;
      if (eig) ip = 0;
      if (edg) dp = 0;
      @(negedge clk);
    end
    idle_inputs(k);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1;
      idle_inputs(k);
      for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
    end
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_latency3();
    test_reset_mid();
    for (int k = 0; k < 3; k++) test_random(k, 400);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
